execute_shift_stage: RTL and testbench
======================================

EXECUTE_SHIFT_STAGE -- requirements
Module: execute_shift_stage

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 32, datapath width; only 32 is supported.
REQ-002 SHALL have clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have flush  input  1  synchronous pipeline flush.
REQ-005 SHALL have in_valid  input  1  upstream operation valid.
REQ-006 SHALL have in_ready  output  1  stage can accept an operation.
REQ-007 SHALL have in_op  input  3  operation: 000 SHL, 001 SHR, 010 SAR, 011 ROL, 100 ROR, 101-111 illegal.
REQ-008 SHALL have in_operand  input  BIT_WIDTH  value to shift.
REQ-009 SHALL have in_count  input  8  raw shift count.
REQ-010 SHALL have in_cf  input  1  current carry flag.
REQ-011 SHALL have out_valid  output  1  result entry available.
REQ-012 SHALL have out_ready  input  1  downstream accepts the result.
REQ-013 SHALL have out_result  output  BIT_WIDTH  shifted or rotated value.
REQ-014 SHALL have out_cf, out_of, out_zf, out_sf, out_pf  output  1 each  computed flags.
REQ-015 SHALL have out_cf_of_we  output  1  CF/OF write enable.
REQ-016 SHALL have out_szp_we  output  1  ZF/SF/PF write enable.
REQ-017 SHALL have out_illegal  output  1  entry came from an illegal in_op.

Function
REQ-018 SHALL accept an operation on a clk edge where in_valid and in_ready are both 1 (push).
REQ-019 SHALL mask the count: c = in_count[4:0]; in_count[7:5] is ignored.
REQ-020 SHALL compute the result and flags combinationally at push and store them in a 2-entry in-order output FIFO; minimum latency is 1 cycle (push edge to out_valid high).
REQ-021 SHALL drive in_ready = (occupancy < 2) and not flush, from registered state only, with no combinational path from out_ready.
REQ-022 SHALL drive out_valid = (occupancy > 0) and present the head entry; a pop occurs on an edge where out_valid and out_ready are both 1.
REQ-023 SHALL apply simultaneous push and pop in the same edge, leaving occupancy unchanged and preserving order.
REQ-024 SHALL hold head outputs stable while out_valid=1 and out_ready=0.
REQ-025 SHL: result = operand << c; CF = operand[32-c]; OF = result[31] XOR CF when c==1, else 0.
REQ-026 SHR: result = operand >> c, zero fill; CF = operand[c-1]; OF = operand[31] when c==1, else 0.
REQ-027 SAR: result = operand >> c, sign fill; CF = operand[c-1]; OF = 0.
REQ-028 ROL: result = operand rotated left by c; CF = result[0]; OF = result[31] XOR CF when c==1, else 0.
REQ-029 ROR: result = operand rotated right by c; CF = result[31]; OF = result[31] XOR result[30] when c==1, else 0.
REQ-030 Flags from every result: ZF = (result==0); SF = result[31]; PF = 1 when result[7:0] has an even number of ones.
REQ-031 Write enables: shifts with c!=0 set cf_of_we=1 and szp_we=1; rotates with c!=0 set cf_of_we=1 and szp_we=0.
REQ-032 When c==0 on any legal op: result = operand, CF = in_cf, both write enables 0.
REQ-033 Illegal op: result = operand, illegal=1, both write enables 0, all flags 0; the entry is queued in order like a legal one.
REQ-034 Flush: on an edge with flush=1, occupancy becomes 0, no push or pop takes effect, and out_valid is 0 on the following cycle.

Reset
REQ-035 While rst_n=0 (asynchronous assertion): occupancy=0, FIFO pointers=0, out_valid=0, and out_result, all flags, write enables and out_illegal are 0.
REQ-036 After rst_n deasserts, in_ready SHALL be 1 from the first clk edge onward (unless flush=1); entries accepted before a mid-operation reset are discarded.

Verification
REQ-037 SHR 0x80000001, count 1 -> result 0x40000000, CF=1, OF=1, ZF=0, SF=0, PF=1, both write enables 1, out_valid 1 cycle after push.
REQ-038 SAR 0x80000000, count 31 -> result 0xFFFFFFFF, CF=0, OF=0, SF=1, ZF=0, PF=1.
REQ-039 SHL 0x80000000, count 0x21 (masked to 1) -> result 0, CF=1, OF=1, ZF=1, PF=1; then ROL 0x80000000, count 0x20 (masked to 0) with in_cf=1 -> result 0x80000000, CF=1, both write enables 0.
REQ-040 out_ready=0 with 3 back-to-back pushes (ROR 0x1 by 1, SHR 0x4 by 2, op 111) -> two are accepted and in_ready=0 holds the third; with out_ready=1 the outputs are, in order, 0x80000000 (CF=1, OF=1, szp_we=0), 0x1 (CF=0), then the illegal entry.
REQ-041 Occupancy 2 and flush=1 -> out_valid=0 on the next cycle and nothing is popped; then rst_n pulsed low mid-stream with occupancy 1 -> out_valid is immediately 0 and all outputs are 0.

Source files
------------

// File: rtl/execute_shift_stage.sv
// rtl/execute_shift_stage.sv - x86-style shift/rotate execute stage with 2-entry in-order result FIFO
module execute_shift_stage #(
    parameter int BIT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_op,
    input  logic [BIT_WIDTH-1:0] in_operand,
    input  logic [7:0]           in_count,
    input  logic                 in_cf,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BIT_WIDTH-1:0] out_result,
    output logic                 out_cf,
    output logic                 out_of,
    output logic                 out_zf,
    output logic                 out_sf,
    output logic                 out_pf,
    output logic                 out_cf_of_we,
    output logic                 out_szp_we,
    output logic                 out_illegal
);

    localparam logic [2:0] OP_SHL = 3'b000;
    localparam logic [2:0] OP_SHR = 3'b001;
    localparam logic [2:0] OP_SAR = 3'b010;
    localparam logic [2:0] OP_ROL = 3'b011;
    localparam logic [2:0] OP_ROR = 3'b100;

    typedef struct packed {
        logic                 illegal;
        logic                 szp_we;
        logic                 cf_of_we;
        logic                 pf;
        logic                 sf;
        logic                 zf;
        logic                 of_f;
        logic                 cf;
        logic [BIT_WIDTH-1:0] result;
    } entry_t;

    entry_t       mem_q [2];
    logic         wr_q;
    logic         rd_q;
    logic [1:0]   cnt_q;
    entry_t       entry_d;
    entry_t       head;
    logic         push;
    logic         pop;

    // Only the low five count bits matter; inv is the complementary shift (32 - c).
    logic [4:0]           cnt;
    logic [5:0]           inv;
    logic [BIT_WIDTH-1:0] rol_v;
    logic [BIT_WIDTH-1:0] ror_v;

    assign cnt   = in_count[4:0];
    assign inv   = 6'd32 - {1'b0, cnt};
    assign rol_v = (in_operand << cnt) | (in_operand >> inv);
    assign ror_v = (in_operand >> cnt) | (in_operand << inv);

    assign in_ready  = (cnt_q != 2'd2) && !flush;
    assign out_valid = (cnt_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready && !flush;

    // Compute the full result entry for the operation currently on the input.
    always_comb begin
        entry_d        = '0;
        entry_d.result = in_operand;
        if (in_op > OP_ROR) begin
            entry_d.illegal = 1'b1;
        end else if (cnt == 5'd0) begin
            entry_d.cf = in_cf;
        end else begin
            case (in_op)
                OP_SHL: begin
                    entry_d.result   = in_operand << cnt;
                    entry_d.cf       = in_operand[inv[4:0]];
                    entry_d.of_f     = (cnt == 5'd1) && (entry_d.result[BIT_WIDTH-1] ^ entry_d.cf);
                    entry_d.cf_of_we = 1'b1;
                    entry_d.szp_we   = 1'b1;
                end
                OP_SHR: begin
                    entry_d.result   = in_operand >> cnt;
                    entry_d.cf       = in_operand[cnt - 5'd1];
                    entry_d.of_f     = (cnt == 5'd1) && in_operand[BIT_WIDTH-1];
                    entry_d.cf_of_we = 1'b1;
                    entry_d.szp_we   = 1'b1;
                end
                OP_SAR: begin
                    entry_d.result   = $unsigned($signed(in_operand) >>> cnt);
                    entry_d.cf       = in_operand[cnt - 5'd1];
                    entry_d.cf_of_we = 1'b1;
                    entry_d.szp_we   = 1'b1;
                end
                OP_ROL: begin
                    entry_d.result   = rol_v;
                    entry_d.cf       = rol_v[0];
                    entry_d.of_f     = (cnt == 5'd1) && (rol_v[BIT_WIDTH-1] ^ rol_v[0]);
                    entry_d.cf_of_we = 1'b1;
                end
                default: begin
                    entry_d.result   = ror_v;
                    entry_d.cf       = ror_v[BIT_WIDTH-1];
                    entry_d.of_f     = (cnt == 5'd1) && (ror_v[BIT_WIDTH-1] ^ ror_v[BIT_WIDTH-2]);
                    entry_d.cf_of_we = 1'b1;
                end
            endcase
        end
        if (!entry_d.illegal) begin
            entry_d.zf = (entry_d.result == '0);
            entry_d.sf = entry_d.result[BIT_WIDTH-1];
            entry_d.pf = ~^entry_d.result[7:0];
        end
    end

    // FIFO storage, pointers and occupancy; flush empties without pushing or popping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else if (flush) begin
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_q] <= entry_d;
                wr_q        <= ~wr_q;
            end
            if (pop) begin
                rd_q <= ~rd_q;
            end
            cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
        end
    end

    // Present the head entry; zero everything when the FIFO is empty.
    always_comb begin
        head = out_valid ? mem_q[rd_q] : '0;
    end

    assign out_result   = head.result;
    assign out_cf       = head.cf;
    assign out_of       = head.of_f;
    assign out_zf       = head.zf;
    assign out_sf       = head.sf;
    assign out_pf       = head.pf;
    assign out_cf_of_we = head.cf_of_we;
    assign out_szp_we   = head.szp_we;
    assign out_illegal  = head.illegal;

endmodule

// File: tb/tb_execute_shift_stage.sv
// tb/tb_execute_shift_stage.sv - scoreboard testbench for execute_shift_stage
module tb_execute_shift_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [31:0] in_operand;
    logic [7:0]  in_count;
    logic        in_cf;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_cf, out_of, out_zf, out_sf, out_pf;
    logic        out_cf_of_we, out_szp_we, out_illegal;

    int checks = 0;
    int errors = 0;
    logic [40:0] exp_q [$];
    logic [40:0] act;

    execute_shift_stage #(.BIT_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_operand(in_operand), .in_count(in_count), .in_cf(in_cf),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_cf(out_cf), .out_of(out_of), .out_zf(out_zf), .out_sf(out_sf), .out_pf(out_pf),
        .out_cf_of_we(out_cf_of_we), .out_szp_we(out_szp_we), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    assign act = {out_illegal, out_szp_we, out_cf_of_we, out_pf, out_sf, out_zf, out_of, out_cf, out_result};

    function automatic logic [40:0] mk(input logic [31:0] res, input logic cf, input logic of_f,
                                       input logic zf, input logic sf, input logic pf,
                                       input logic cfwe, input logic szpwe, input logic ill);
        return {ill, szpwe, cfwe, pf, sf, zf, of_f, cf, res};
    endfunction

    task automatic check(input string name, input logic [40:0] got, input logic [40:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // Monitor: head must match the scoreboard front whenever valid; a handshake retires it.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", act, '0);
                end else begin
                    check("head_entry", act, exp_q[0]);
                    if (out_ready === 1'b1) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] opd, input logic [7:0] cnt,
                         input logic cf, input logic [40:0] e);
        bit done = 0;
        in_valid   = 1'b1;
        in_op      = op;
        in_operand = opd;
        in_count   = cnt;
        in_cf      = cf;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                @(posedge clk);
                exp_q.push_back(e);
                done = 1;
            end else begin
                @(posedge clk);
            end
            #1;
        end
        in_valid = 1'b0;
        if (!done) check("issue_timeout", 41'd0, 41'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
        check("drain_empty", 41'(exp_q.size()), 41'd0);
        @(negedge clk);
        check("drained_out_valid", 41'(out_valid), 41'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_op = 3'd0;
        in_operand = '0; in_count = '0; in_cf = 1'b0; out_ready = 1'b1;
        #1;
        check("reset_outputs", act, '0);
        check("reset_out_valid", 41'(out_valid), 41'd0);
        #12 rst_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("ready_after_reset", 41'(in_ready), 41'd1);
        @(posedge clk); #1;

        // SHR with one-cycle latency check
        issue(3'b001, 32'h8000_0001, 8'd1, 1'b0, mk(32'h4000_0000, 1, 1, 0, 0, 1, 1, 1, 0));
        @(negedge clk);
        check("latency_out_valid", 41'(out_valid), 41'd1);
        @(posedge clk); #1;
        issue(3'b010, 32'h8000_0000, 8'd31,   1'b0, mk(32'hFFFF_FFFF, 0, 0, 0, 1, 1, 1, 1, 0));
        issue(3'b000, 32'h8000_0000, 8'h21,   1'b0, mk(32'h0000_0000, 1, 1, 1, 0, 1, 1, 1, 0));
        issue(3'b011, 32'h8000_0000, 8'h20,   1'b1, mk(32'h8000_0000, 1, 0, 0, 1, 1, 0, 0, 0));
        issue(3'b000, 32'h0000_0003, 8'd4,    1'b0, mk(32'h0000_0030, 0, 0, 0, 0, 1, 1, 1, 0));
        issue(3'b011, 32'h8000_0001, 8'd1,    1'b0, mk(32'h0000_0003, 1, 1, 0, 0, 1, 1, 0, 0));
        issue(3'b001, 32'h0000_0000, 8'd0,    1'b0, mk(32'h0000_0000, 0, 0, 1, 0, 1, 0, 0, 0));
        drain();

        // Backpressure: two accepted, third held until downstream drains
        out_ready = 1'b0;
        issue(3'b100, 32'h0000_0001, 8'd1, 1'b0, mk(32'h8000_0000, 1, 1, 0, 1, 1, 1, 0, 0));
        issue(3'b001, 32'h0000_0004, 8'd2, 1'b0, mk(32'h0000_0001, 0, 0, 0, 0, 0, 1, 1, 0));
        in_valid = 1'b1; in_op = 3'b111; in_operand = 32'h55; in_count = 8'd3; in_cf = 1'b1;
        @(negedge clk);
        check("full_in_ready", 41'(in_ready), 41'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("full_in_ready_hold", 41'(in_ready), 41'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        issue(3'b111, 32'h0000_0055, 8'd3, 1'b1, mk(32'h0000_0055, 0, 0, 0, 0, 0, 0, 0, 1));
        drain();

        // Flush with two entries queued
        out_ready = 1'b0;
        issue(3'b000, 32'h0000_0003, 8'd4, 1'b0, mk(32'h0000_0030, 0, 0, 0, 0, 1, 1, 1, 0));
        issue(3'b010, 32'h8000_0000, 8'd31, 1'b0, mk(32'hFFFF_FFFF, 0, 0, 0, 1, 1, 1, 1, 0));
        flush = 1'b1;
        @(negedge clk);
        check("flush_in_ready", 41'(in_ready), 41'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("flush_out_valid", 41'(out_valid), 41'd0);
        @(posedge clk); #1;

        // Asynchronous reset mid-stream with one entry queued
        issue(3'b100, 32'h0000_0001, 8'd1, 1'b0, mk(32'h8000_0000, 1, 1, 0, 1, 1, 1, 0, 0));
        #2 rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("async_reset_out_valid", 41'(out_valid), 41'd0);
        check("async_reset_outputs", act, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_in_ready", 41'(in_ready), 41'd1);
        check("post_reset_out_valid", 41'(out_valid), 41'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        issue(3'b100, 32'h0000_0001, 8'd1, 1'b0, mk(32'h8000_0000, 1, 1, 0, 1, 1, 1, 0, 0));
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
